// File: rtl/hs_pkg.sv
// Shared definitions for the handshake FIFO and its neighbouring pipeline stages.
package hs_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/hs_fifo_ptr.sv
// Wrapping FIFO pointer; advances by one when inc is high and wraps at DEPTH.
module hs_fifo_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // DEPTH is a power of two, so natural overflow gives the wrap to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PtrW'(1);
    end
  end

endmodule

// File: rtl/hs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   master_valid_in,
  input  logic [DATA_W-1:0]      master_data_in,
  output logic                   slave_ready_out,
  output logic                   master_valid_out,
  output logic [DATA_W-1:0]      master_data_out,
  input  logic                   slave_ready_in,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic                   almost_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  data_t             mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic              push;
  logic              pop;

  // Handshake outputs depend only on the registered count.
  assign slave_ready_out  = (count_q != CntW'(DEPTH));
  assign master_valid_out = (count_q != '0);
  assign almost_full      = (count_q >= CntW'(AF_LEVEL));
  assign fill_count       = count_q;

  assign push = master_valid_in & slave_ready_out;
  assign pop  = master_valid_out & slave_ready_in;

  // Stale storage is masked while empty.
  assign master_data_out = master_valid_out ? mem_q[rd_ptr] : '0;

  hs_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  hs_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= master_data_in;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Scoreboard bench for hs_sync_fifo: directed phases plus random valid/ready traffic.
module tb_hs_sync_fifo;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 3;
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst;
  logic            master_valid_in;
  logic [15:0]     master_data_in;
  logic            slave_ready_out;
  logic            master_valid_out;
  logic [15:0]     master_data_out;
  logic            slave_ready_in;
  logic [CntW-1:0] fill_count;
  logic            almost_full;

  int checks;
  int errors;

  // Expected contents of the FIFO, head first.
  logic [15:0] exp_q [$];
  logic [15:0] popped_q [$];

  hs_sync_fifo #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .master_valid_in  (master_valid_in),
    .master_data_in   (master_data_in),
    .slave_ready_out  (slave_ready_out),
    .master_valid_out (master_valid_out),
    .master_data_out  (master_data_out),
    .slave_ready_in   (slave_ready_in),
    .fill_count       (fill_count),
    .almost_full      (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare at the falling edge, commit the model's handshakes at the rising edge.
  initial begin : monitor
    logic        pend_push;
    logic        pend_pop;
    logic [15:0] pend_data;
    logic        stalled;
    logic [15:0] stall_data;
    int          sz;
    stalled = 1'b0;
    stall_data = '0;
    forever begin
      pend_push = 1'b0;
      pend_pop  = 1'b0;
      pend_data = '0;
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        stalled = 1'b0;
        chk("rst_ready", 32'(slave_ready_out), 32'd1);
        chk("rst_valid", 32'(master_valid_out), 32'd0);
        chk("rst_data", 32'(master_data_out), 32'd0);
        chk("rst_count", 32'(fill_count), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
      end else begin
        sz = exp_q.size();
        chk("fill_count", 32'(fill_count), 32'(sz));
        chk("ready_out", 32'(slave_ready_out), 32'(sz != DEPTH));
        chk("valid_out", 32'(master_valid_out), 32'(sz != 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF_LEVEL));
        chk("data_out", 32'(master_data_out), (sz != 0) ? 32'(exp_q[0]) : 32'd0);
        if (stalled && master_valid_out) begin
          chk("stall_stable", 32'(master_data_out), 32'(stall_data));
        end
        stalled    = (sz != 0) && !slave_ready_in;
        stall_data = master_data_out;
        pend_pop   = (sz != 0) && slave_ready_in;
        pend_push  = master_valid_in && (sz != DEPTH);
        pend_data  = master_data_in;
      end
      @(posedge clk);
      if (pend_pop) popped_q.push_back(exp_q.pop_front());
      if (pend_push) exp_q.push_back(pend_data);
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic r);
    master_valid_in = v;
    master_data_in  = d;
    slave_ready_in  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_popped(input string name, input logic [15:0] exp);
    if (popped_q.size() == 0) begin
      chk({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      chk(name, 32'(popped_q.pop_front()), 32'(exp));
    end
  endtask

  initial begin : driver
    rst             = 1'b0;
    master_valid_in = 1'b0;
    master_data_in  = '0;
    slave_ready_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b0);
    // Full: offer a word while popping; only the pop happens.
    cyc(1'b1, 16'h0014, 1'b1);
    expect_popped("full_pop", 16'h0010);
    repeat (4) cyc(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) expect_popped("drain_after_full", 16'(16'h0011 + i));
    chk("no_0014", 32'(popped_q.size()), 32'd0);

    // Streaming with both sides ready.
    for (int i = 16; i < 80; i++) cyc(1'b1, 16'(i), 1'b1);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1);
    for (int i = 16; i < 80; i++) expect_popped("stream", 16'(i));

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (6) cyc(1'b0, 16'h0000, 1'b1);
    popped_q.delete();

    // Pointer wrap at a steady fill level of 2.
    cyc(1'b1, 16'h0100, 1'b0);
    cyc(1'b1, 16'h0101, 1'b0);
    for (int i = 2; i < 12; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b1);
    repeat (3) cyc(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 12; i++) expect_popped("wrap", 16'(16'h0100 + i));

    // Reset with two words held.
    cyc(1'b1, 16'h0055, 1'b0);
    cyc(1'b1, 16'h0056, 1'b0);
    master_valid_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(master_valid_out), 32'd0);
    chk("async_rst_count", 32'(fill_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 16'h00AA, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    repeat (2) cyc(1'b0, 16'h0000, 1'b0);
    expect_popped("after_rst", 16'h00AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_sync_fifo.md
HS_SYNC_FIFO -- requirements
Module: hs_sync_fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; SHALL be a power of two and at least 2.
REQ-002 Parameter AF_LEVEL, default DEPTH-1: fill level at which almost_full asserts; SHALL satisfy 1 <= AF_LEVEL <= DEPTH.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 master_valid_in  input  1  upstream data valid.
REQ-006 master_data_in  input  16  upstream data.
REQ-007 slave_ready_out  output  1  FIFO can accept a word.
REQ-008 master_valid_out  output  1  FIFO holds a word for downstream.
REQ-009 master_data_out  output  16  head-of-queue word.
REQ-010 slave_ready_in  input  1  downstream accepts a word.
REQ-011 fill_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 almost_full  output  1  fill_count >= AF_LEVEL.

Function
REQ-013 Push SHALL occur on a rising edge when master_valid_in & slave_ready_out; the word is written at wr_ptr and wr_ptr advances.
REQ-014 Pop SHALL occur on a rising edge when master_valid_out & slave_ready_in; rd_ptr advances.
REQ-015 slave_ready_out SHALL be (fill_count != DEPTH), driven from registered state only, with no combinational path from slave_ready_in.
REQ-016 master_valid_out SHALL be (fill_count != 0), driven from registered state only, with no combinational path from master_valid_in.
REQ-017 First-word-fall-through: master_data_out SHALL equal mem[rd_ptr] whenever master_valid_out=1, and 16'h0000 when empty.
REQ-018 Latency: a word pushed at edge N SHALL be visible on master_data_out after edge N if the FIFO was empty.
REQ-019 While master_valid_out=1 and slave_ready_in=0, master_data_out SHALL hold stable.
REQ-020 Simultaneous push and pop (0 < fill_count < DEPTH): both SHALL occur in the same cycle and fill_count SHALL remain unchanged.
REQ-021 Full: a push SHALL be blocked even if a pop occurs in the same cycle; that cycle's pop SHALL reduce fill_count to DEPTH-1.
REQ-022 Empty: no pop SHALL occur; a push SHALL increment fill_count to 1.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without loss or reordering.
REQ-024 fill_count SHALL update as +1 on push only, -1 on pop only, and 0 change otherwise.
REQ-025 Order SHALL be strictly first-in, first-out; no word SHALL be dropped or duplicated.

Reset
REQ-026 When rst=0, wr_ptr, rd_ptr and fill_count SHALL clear to 0 immediately (asynchronously).
REQ-027 Reset values: slave_ready_out=1, master_valid_out=0, master_data_out=0, fill_count=0, almost_full=0.
REQ-028 Storage contents need not be reset; stale data SHALL never be presented because of REQ-017.
REQ-029 Reset asserted mid-transfer SHALL discard all held words; after release, the first pushed word SHALL be the first popped.

Structure
REQ-030 Shared package hs_pkg SHALL hold localparam DATA_W=16, which this block and the pipeline stages share.
REQ-031 A single sub-module hs_fifo_ptr (wrapping pointer with an increment enable) SHALL be instantiated twice, for read and write.
REQ-032 Storage SHALL be a register array of DEPTH x DATA_W, written synchronously and read combinationally.

Verification (DEPTH=4, AF_LEVEL=3)
REQ-033 After reset, push 16'h0010..16'h0013 with slave_ready_in=0 -> fill_count steps 1,2,3,4; almost_full=1 at 3; slave_ready_out=0 at 4; master_data_out=16'h0010 throughout.
REQ-034 When full, offer 16'h0014 while popping -> 16'h0010 is popped, 16'h0014 is not accepted, and fill_count=3.
REQ-035 Stream 64 words (16..79) with both sides always ready -> output sequence is 16..79 in order, with a 1-cycle first-word latency and fill_count constant at 1.
REQ-036 Random valid/ready toggling for 500 cycles -> the scoreboard matches, with no overflow or underflow, and data is stable while stalled.
REQ-037 Assert rst low with 2 words held -> outputs are at reset values the same cycle; after release, push 16'h00AA -> 16'h00AA is the first word popped.
REQ-038 Pointer wrap: run 10 push/pop cycles at fill_count=2 -> pointers wrap 3->0 and the data order is preserved.
